instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: IDLE/FETCH/DECODE/EXECUTE/WRITEBACK/TRAP with fetch timeout and illegal-instruction trap.
// Define PERF_CNT_EN to build the retired-instruction counter; otherwise retired_cnt reads 0.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        cu_reg_wen,
  input  logic        cu_reg_flag,
  output logic        alu_en,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP} state_e;

  localparam logic [7:0] TIMEOUT_CNT   = 8'(IMEM_TIMEOUT);
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_FETCH   = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        stop_pend_q, stop_pend_d;
  logic [1:0]  cause_q, cause_d;
  logic        imem_req_q, imem_req_d;
  logic        alu_en_q, alu_en_d;
  logic        rf_we_q, rf_we_d;
  logic        busy_q, busy_d;
  logic        trap_q, trap_d;
  logic        unused_cu_reg_flag;

  // Loads finish in EXECUTE like any ALU op, so the load flag needs no extra state.
  assign unused_cu_reg_flag = cu_reg_flag;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    wait_d      = wait_q;
    cause_d     = cause_q;
    stop_pend_d = stop_pend_q | (stop_req && (state_q != IDLE) && (state_q != TRAP));
    case (state_q)
      IDLE: if (start) state_d = FETCH;
      FETCH: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          wait_d  = '0;
          state_d = DECODE;
        end else if (wait_q + 8'd1 == TIMEOUT_CNT) begin
          wait_d  = '0;
          cause_d = CAUSE_FETCH;
          state_d = TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        if (!cu_reg_wen) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = TRAP;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: state_d = WRITEBACK;
      WRITEBACK: begin
        pc_d = pc_q + 32'd4;
        if (stop_pend_d) begin
          stop_pend_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      TRAP: begin
        if (start) begin
          pc_d        = RESET_PC;
          cause_d     = CAUSE_NONE;
          stop_pend_d = 1'b0;
          state_d     = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    imem_req_d = (state_d == FETCH);
    alu_en_d   = (state_d == EXECUTE);
    rf_we_d    = (state_d == WRITEBACK);
    busy_d     = (state_d == FETCH) || (state_d == DECODE) ||
                 (state_d == EXECUTE) || (state_d == WRITEBACK);
    trap_d     = (state_d == TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      wait_q      <= '0;
      stop_pend_q <= 1'b0;
      cause_q     <= CAUSE_NONE;
      imem_req_q  <= 1'b0;
      alu_en_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      wait_q      <= wait_d;
      stop_pend_q <= stop_pend_d;
      cause_q     <= cause_d;
      imem_req_q  <= imem_req_d;
      alu_en_q    <= alu_en_d;
      rf_we_q     <= rf_we_d;
      busy_q      <= busy_d;
      trap_q      <= trap_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Survives TRAP restart; only reset clears it.
  always_comb retired_d = (state_q == WRITEBACK) ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = '0;
`endif

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign ir         = ir_q;
  assign alu_en     = alu_en_q;
  assign rf_we      = rf_we_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed runs push expected writeback/trap events; a monitor pops and compares.
module tb_instr_sequencer;
  localparam logic [31:0] ADD_W = 32'h0020_81B3;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n, start, stop_req, imem_ack, cu_reg_wen, cu_reg_flag;
  logic [31:0] imem_rdata;
  logic        imem_req, alu_en, rf_we, busy, trap;
  logic [31:0] imem_addr, ir, pc, retired_cnt;
  logic [1:0]  trap_cause;

  logic        start_w, stop_w, ack_w, cu_w, flag_w;
  logic        imem_req_w, alu_en_w, rf_we_w, busy_w, trap_w;
  logic [31:0] imem_addr_w, ir_w, pc_w, retired_w;
  logic [1:0]  trap_cause_w;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .cu_reg_wen(cu_reg_wen), .cu_reg_flag(cu_reg_flag),
    .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .busy(busy), .trap(trap),
    .trap_cause(trap_cause), .retired_cnt(retired_cnt)
  );

  instr_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .stop_req(stop_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(ack_w), .imem_rdata(ADD_W),
    .ir(ir_w), .cu_reg_wen(cu_w), .cu_reg_flag(flag_w),
    .alu_en(alu_en_w), .rf_we(rf_we_w), .pc(pc_w), .busy(busy_w), .trap(trap_w),
    .trap_cause(trap_cause_w), .retired_cnt(retired_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    logic [31:0] pc;
    logic [1:0]  cause;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, wb_cnt = 0, trap_cnt = 0, alu_cnt = 0;
  int  wb_cyc_last = 0, wb_gap = 0;
  int  ack_delay = 0, fetch_n = 0, fetch_n_last = 0;
  bit  trap_seen = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input bit t, input logic [31:0] p, input logic [1:0] c);
    ev_t e;
    e.is_trap = t;
    e.pc      = p;
    e.cause   = c;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input bit t, input logic [31:0] p, input logic [1:0] c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got trap=%0d pc=%h cause=%b, required no event", t, p, c);
    end else begin
      e = exp_q.pop_front();
      if (e.is_trap != t || e.pc !== p || (t && e.cause !== c)) begin
        errors++;
        $display("FAIL event: got trap=%0d pc=%h cause=%b, required trap=%0d pc=%h cause=%b",
                 t, p, c, e.is_trap, e.pc, e.cause);
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every writeback and every trap entry must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (alu_en) alu_cnt++;
      if (rf_we) begin
        wb_gap      = cyc - wb_cyc_last;
        wb_cyc_last = cyc;
        wb_cnt++;
        mon_event(1'b0, pc, 2'b00);
      end
      if (trap && !trap_seen) begin
        trap_cnt++;
        mon_event(1'b1, pc, trap_cause);
      end
      trap_seen = trap;
    end else begin
      trap_seen = 1'b0;
    end
  end

  // Memory responder: ack in FETCH cycle ack_delay+1 (255 = never).
  initial begin
    imem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (imem_req) fetch_n++;
        else          fetch_n = 0;
        if (fetch_n > 0) fetch_n_last = fetch_n;
        imem_ack = imem_req && (fetch_n == ack_delay + 1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_wb(input int target, input int budget);
    int n = 0;
    while (wb_cnt < target && n < budget) begin step(); n++; end
    if (wb_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_wb: got %0d writebacks, required %0d", wb_cnt, target);
    end
  endtask

  task automatic wait_trap(input int target, input int budget);
    int n = 0;
    while (trap_cnt < target && n < budget) begin step(); n++; end
    if (trap_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_trap: got %0d traps, required %0d", trap_cnt, target);
    end
  endtask

  task automatic wait_alu(input int budget);
    int n = 0;
    while (!alu_en && n < budget) begin step(); n++; end
    if (!alu_en) begin
      checks++; errors++;
      $display("FAIL wait_alu: got alu_en=0, required 1");
    end
  endtask

  initial begin
    int a0, w0, nw;
    logic [31:0] wpc [3];
    rst_n = 1'b0; start = 1'b0; stop_req = 1'b0; cu_reg_wen = 1'b1; cu_reg_flag = 1'b0;
    imem_rdata = ADD_W;
    start_w = 1'b0; stop_w = 1'b0; ack_w = 1'b1; cu_w = 1'b1; flag_w = 1'b0;
    #1;
    chk32("rst_imem_req", imem_req, 0);
    chk32("rst_busy", busy, 0);
    chk32("rst_pc", pc, 32'h0);
    chk32("rst_ir", ir, 32'h0);
    chk32("rst_trap", {trap, trap_cause}, 0);
    chk32("rst_strobes", {alu_en, rf_we}, 0);
    chk32("rst_retired", retired_cnt, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk32("idle_after_rst", {busy, imem_req}, 0);

    // Three back-to-back adds at 4 cycles each, stopped during the third.
    ack_delay = 0;
    push_ev(1'b0, 32'd0, 2'b00);
    push_ev(1'b0, 32'd4, 2'b00);
    push_ev(1'b0, 32'd8, 2'b00);
    start = 1'b1; step(); start = 1'b0;
    chk32("fetch_req", {imem_req, busy}, 2'b11);
    chk32("fetch_addr", imem_addr, 32'd0);
    wait_wb(2, 40);
    step(); stop_req = 1'b1; step(); stop_req = 1'b0;
    wait_wb(3, 40);
    chk32("wb_spacing", wb_gap, 4);
    step();
    chk32("stop_idle_busy", busy, 0);
    chk32("stop_idle_pc", pc, 32'd12);
    chk32("ir_latched", ir, ADD_W);
    chk32("alu_pulses", alu_cnt, 3);
    chk32("retired_3", retired_cnt, PERF ? 32'd3 : 32'd0);

    // stop_req pulse during EXECUTE.
    push_ev(1'b0, 32'd12, 2'b00);
    start = 1'b1; step(); start = 1'b0;
    wait_alu(10);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    wait_wb(4, 10);
    step();
    chk32("exec_stop_pc", pc, 32'd16);
    repeat (3) step();
    chk32("exec_stop_idle", {busy, imem_req}, 0);

    // Resume at pc 16, fetch never acked -> timeout trap.
    ack_delay = 255;
    push_ev(1'b1, 32'd16, 2'b01);
    start = 1'b1; step(); start = 1'b0;
    chk32("resume_addr", imem_addr, 32'd16);
    wait_trap(1, 40);
    chk32("to_trap", {trap, trap_cause}, 3'b101);
    chk32("to_pc", pc, 32'd16);
    chk32("to_quiet", {busy, imem_req, alu_en, rf_we}, 0);
    chk32("to_fetch_cycles", fetch_n_last, 15);
    repeat (3) step();
    chk32("trap_held", {trap, trap_cause}, 3'b101);

    // Restart from TRAP; ack on the 15th FETCH cycle must win.
    ack_delay = 14;
    push_ev(1'b0, 32'd0, 2'b00);
    start = 1'b1; step(); start = 1'b0;
    chk32("restart_clear", {trap, trap_cause}, 0);
    chk32("restart_addr", imem_addr, 32'd0);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    wait_wb(5, 40);
    step();
    chk32("late_ack_pc", pc, 32'd4);
    chk32("late_ack_notrap", {trap, busy}, 0);

    // Illegal instruction: no execute or writeback strobes.
    ack_delay = 0; cu_reg_wen = 1'b0;
    a0 = alu_cnt; w0 = wb_cnt;
    push_ev(1'b1, 32'd4, 2'b10);
    start = 1'b1; step(); start = 1'b0;
    wait_trap(2, 20);
    repeat (2) step();
    chk32("ill_no_alu", alu_cnt, a0);
    chk32("ill_no_wb", wb_cnt, w0);
    chk32("ill_cause", {trap, trap_cause}, 3'b110);
    chk32("ill_pc", pc, 32'd4);

    // Restart with a load (cu_reg_flag=1): same 4-cycle path.
    cu_reg_wen = 1'b1; cu_reg_flag = 1'b1;
    push_ev(1'b0, 32'd0, 2'b00);
    start = 1'b1; step(); start = 1'b0;
    stop_req = 1'b1; step(); stop_req = 1'b0;
    wait_wb(6, 20);
    step();
    cu_reg_flag = 1'b0;
    chk32("load_pc", pc, 32'd4);
    chk32("retired_6", retired_cnt, PERF ? 32'd6 : 32'd0);

    // Reset asserted mid-FETCH, with ack held during reset.
    ack_delay = 255;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk32("midfetch_req", imem_req, 1);
    rst_n = 1'b0; imem_ack = 1'b1;
    #1;
    chk32("async_req", {imem_req, busy}, 0);
    chk32("async_pc", pc, 32'd0);
    chk32("async_ir", ir, 32'd0);
    chk32("async_retired", retired_cnt, 0);
    repeat (2) step();
    rst_n = 1'b1; imem_ack = 1'b0;
    repeat (4) step();
    chk32("post_rst_idle", {busy, imem_req, trap}, 0);
    chk32("post_rst_ir", ir, 32'd0);

    // PC wrap on the second instance starting at FFFF_FFF8.
    nw = 0;
    start_w = 1'b1; step(); start_w = 1'b0;
    for (int i = 0; i < 40 && !(nw == 3 && !busy_w); i++) begin
      if (rf_we_w) begin
        wpc[nw] = pc_w;
        nw++;
      end
      if (nw == 2 && !rf_we_w) stop_w = 1'b1;
      if (nw == 3) stop_w = 1'b0;
      step();
    end
    chk32("wrap_count", nw, 3);
    if (nw == 3) begin
      chk32("wrap_pc1", wpc[1], 32'hFFFF_FFFC);
      chk32("wrap_pc2", wpc[2], 32'h0000_0000);
    end
    chk32("wrap_final_pc", pc_w, 32'd4);
    chk32("wrap_idle", {busy_w, trap_w}, 0);
    chk32("wrap_retired", retired_w, PERF ? 32'd3 : 32'd0);

    chk32("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
